// File: rtl/junction_pkg.sv
// Shared encodings for the junction phase sequencer: phase codes and approach numbers.
package junction_pkg;

   localparam logic [1:0] ALL_RED = 2'd0;
   localparam logic [1:0] GREEN   = 2'd1;
   localparam logic [1:0] YELLOW  = 2'd2;

   typedef enum logic [1:0] {
      StAllRed = ALL_RED,
      StGreen  = GREEN,
      StYellow = YELLOW
   } phase_e;

   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_E = 2'd1;
   localparam logic [1:0] DIR_S = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

endpackage

// File: rtl/sec_tick_sync.sv
// Brings the 1 Hz square wave into the clk domain and emits a one-cycle pulse per rising edge.
module sec_tick_sync (
   input  logic clk,
   input  logic rst,
   input  logic sec_in,
   output logic tick
);

   logic sync1_q, sync2_q, prev_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sec_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Pulse is live in the cycle after the second sync stage goes high, so the
   // consumer's state moves on the third clk edge after the sec_in rise.
   assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/junction_phase_sequencer.sv
// Four-approach green/yellow/all-red sequencer paced by a 1 Hz tick.
// Optional emergency preemption is compiled in when PREEMPT_EN is defined.
module junction_phase_sequencer
   import junction_pkg::*;
#(
   parameter int unsigned GREEN_SEC  = 10,
   parameter int unsigned YELLOW_SEC = 3,
   parameter int unsigned ALLRED_SEC = 1,
   parameter int unsigned CNT_W      = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sec_in,
   input  logic [3:0]       veh_req,
   output logic [3:0]       red,
   output logic [3:0]       yellow,
   output logic [3:0]       green,
   output logic [1:0]       active_dir,
   output logic [CNT_W-1:0] remaining
`ifdef PREEMPT_EN
   ,
   input  logic             preempt_valid,
   input  logic [1:0]       preempt_dir
`endif
);

   localparam logic [CNT_W-1:0] GreenLd  = CNT_W'(GREEN_SEC);
   localparam logic [CNT_W-1:0] YellowLd = CNT_W'(YELLOW_SEC);
   localparam logic [CNT_W-1:0] AllRedLd = CNT_W'(ALLRED_SEC);
   localparam logic [CNT_W-1:0] One      = CNT_W'(1);

   logic             tick;
   phase_e           state_q, state_d;
   logic [1:0]       dir_q, dir_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [3:0]       red_q, red_d, yellow_q, yellow_d, green_q, green_d;
   logic             hold, force_yellow;
   logic [1:0]       sel_dir;

   sec_tick_sync u_sec_tick_sync (
      .clk    (clk),
      .rst    (rst),
      .sec_in (sec_in),
      .tick   (tick)
   );

   // Lowest offset from cur+1 wins; offset 4 wraps to cur itself, so the
   // current approach is reached only when no other approach requests.
   function automatic logic [1:0] rr_next(input logic [1:0] cur, input logic [3:0] req);
      logic [1:0] cand;
      rr_next = cur + 2'd1;
      for (int i = 4; i >= 1; i--) begin
         cand = cur + 2'(i);
         if (req[cand]) rr_next = cand;
      end
   endfunction

   always_comb begin
`ifdef PREEMPT_EN
      hold         = preempt_valid && (state_q == StGreen) && (dir_q == preempt_dir);
      force_yellow = preempt_valid && (state_q == StGreen) && (dir_q != preempt_dir);
      sel_dir      = preempt_valid ? preempt_dir : rr_next(dir_q, veh_req);
`else
      hold         = 1'b0;
      force_yellow = 1'b0;
      sel_dir      = rr_next(dir_q, veh_req);
`endif
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      if (hold) begin
         rem_d = GreenLd;
      end else if (force_yellow) begin
         state_d = StYellow;
         rem_d   = YellowLd;
      end else if (tick) begin
         if (rem_q > One) begin
            rem_d = rem_q - One;
         end else begin
            unique case (state_q)
               StGreen: begin
                  state_d = StYellow;
                  rem_d   = YellowLd;
               end
               StYellow: begin
                  state_d = StAllRed;
                  rem_d   = AllRedLd;
               end
               StAllRed: begin
                  state_d = StGreen;
                  rem_d   = GreenLd;
                  dir_d   = sel_dir;
               end
               default: begin
                  state_d = StAllRed;
                  rem_d   = AllRedLd;
               end
            endcase
         end
      end
   end

   // Lamps are decoded from the next state so they change on the same edge.
   always_comb begin
      red_d    = 4'hF;
      yellow_d = 4'h0;
      green_d  = 4'h0;
      unique case (state_d)
         StGreen: begin
            red_d[dir_d]   = 1'b0;
            green_d[dir_d] = 1'b1;
         end
         StYellow: begin
            red_d[dir_d]    = 1'b0;
            yellow_d[dir_d] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StAllRed;
         dir_q    <= DIR_W;
         rem_q    <= AllRedLd;
         red_q    <= 4'hF;
         yellow_q <= 4'h0;
         green_q  <= 4'h0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         rem_q    <= rem_d;
         red_q    <= red_d;
         yellow_q <= yellow_d;
         green_q  <= green_d;
      end
   end

   assign red        = red_q;
   assign yellow     = yellow_q;
   assign green      = green_q;
   assign active_dir = dir_q;
   assign remaining  = rem_q;

endmodule

// File: tb/tb_junction_phase_sequencer.sv
// Bench for junction_phase_sequencer: directed scenarios plus random requests vs a phase model.
module tb_junction_phase_sequencer;

   localparam int G_SEC = 3;
   localparam int Y_SEC = 2;
   localparam int R_SEC = 1;
   localparam int CW    = 6;

   localparam int PH_AR = 0;
   localparam int PH_G  = 1;
   localparam int PH_Y  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sec_in = 1'b0;
   logic [3:0]    veh_req = 4'h0;
   logic          preempt_valid = 1'b0;
   logic [1:0]    preempt_dir = 2'd0;
   logic [3:0]    red, yellow, green;
   logic [1:0]    active_dir;
   logic [CW-1:0] remaining;

   int n_cmp = 0;
   int n_bad = 0;
   int m_phase, m_dir, m_rem;
   int since_rise = 1000;
   int guard;
   logic [3:0] exp_red, exp_yel, exp_grn;

   always #5 clk = ~clk;

   junction_phase_sequencer #(
      .GREEN_SEC  (G_SEC),
      .YELLOW_SEC (Y_SEC),
      .ALLRED_SEC (R_SEC),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sec_in     (sec_in),
      .veh_req    (veh_req),
      .red        (red),
      .yellow     (yellow),
      .green      (green),
      .active_dir (active_dir),
      .remaining  (remaining)
`ifdef PREEMPT_EN
      ,
      .preempt_valid (preempt_valid),
      .preempt_dir   (preempt_dir)
`endif
   );

   function automatic int pick_next(input int cur, input logic [3:0] req);
      for (int k = 1; k <= 4; k++) begin
         if (req[(cur + k) % 4]) return (cur + k) % 4;
      end
      return (cur + 1) % 4;
   endfunction

   task automatic model_reset();
      m_phase = PH_AR;
      m_dir   = 3;
      m_rem   = R_SEC;
   endtask

   task automatic model_edge(input bit tick_now);
      if (preempt_valid && m_phase == PH_G && m_dir == int'(preempt_dir)) begin
         m_rem = G_SEC;
      end else if (preempt_valid && m_phase == PH_G) begin
         m_phase = PH_Y;
         m_rem   = Y_SEC;
      end else if (tick_now) begin
         if (m_rem > 1) m_rem = m_rem - 1;
         else if (m_phase == PH_G) begin
            m_phase = PH_Y;
            m_rem   = Y_SEC;
         end else if (m_phase == PH_Y) begin
            m_phase = PH_AR;
            m_rem   = R_SEC;
         end else begin
            m_dir   = preempt_valid ? int'(preempt_dir) : pick_next(m_dir, veh_req);
            m_phase = PH_G;
            m_rem   = G_SEC;
         end
      end
   endtask

   task automatic check_all(input string tag);
      exp_red = 4'hF;
      exp_yel = 4'h0;
      exp_grn = 4'h0;
      if (m_phase != PH_AR) exp_red[m_dir] = 1'b0;
      if (m_phase == PH_G) exp_grn[m_dir] = 1'b1;
      if (m_phase == PH_Y) exp_yel[m_dir] = 1'b1;
      n_cmp++;
      assert (remaining === CW'(m_rem)) else begin
         n_bad++;
         $error("FAIL %s remaining got %0d want %0d", tag, remaining, m_rem);
      end
      n_cmp++;
      assert (active_dir === 2'(m_dir)) else begin
         n_bad++;
         $error("FAIL %s active_dir got %0d want %0d", tag, active_dir, m_dir);
      end
      n_cmp++;
      assert ({red, yellow, green} === {exp_red, exp_yel, exp_grn}) else begin
         n_bad++;
         $error("FAIL %s lamps r/y/g got %h/%h/%h want %h/%h/%h", tag, red, yellow, green,
                exp_red, exp_yel, exp_grn);
      end
      n_cmp++;
      assert (((red | yellow | green) === 4'hF) && (((red & yellow) | (red & green) |
              (yellow & green)) === 4'h0) && ($countones(~red) <= 1)) else begin
         n_bad++;
         $error("FAIL %s lamp_invariant got r/y/g %h/%h/%h want one lamp each", tag, red,
                yellow, green);
      end
   endtask

   task automatic clk_step(input string tag);
      bit tick_now;
      @(posedge clk);
      #1;
      since_rise++;
      tick_now = (since_rise == 3);
      if (!rst) model_reset();
      else model_edge(tick_now);
      check_all(tag);
   endtask

   task automatic run_second(input int hi, input int lo, input string tag);
      sec_in = 1'b1;
      since_rise = 0;
      repeat (hi) clk_step(tag);
      sec_in = 1'b0;
      repeat (lo) clk_step(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      repeat (3) clk_step(tag);
      rst = 1'b1;
   endtask

   initial begin
      model_reset();

      // Reset state, then full rotation with every approach requesting.
      veh_req = 4'hF;
      do_reset("reset");
      repeat (26) run_second(10, 10, "all_req");

      // Single requester keeps getting re-served.
      veh_req = 4'b0100;
      repeat (18) run_second(10, 10, "only_s");

      // No requests: fixed-time rotation.
      veh_req = 4'h0;
      repeat (26) run_second(10, 10, "no_req");

      // Reset asserted during E green with remaining=2.
      do_reset("reset2");
      veh_req = 4'hF;
      guard = 0;
      while (!(m_phase == PH_G && m_dir == 1 && m_rem == 2) && guard < 40) begin
         run_second(10, 10, "to_e_green");
         guard++;
      end
      n_cmp++;
      assert (guard < 40) else begin
         n_bad++;
         $error("FAIL reach_e_green got %0d seconds want < 40", guard);
      end
      rst = 1'b0;
      clk_step("mid_reset");
      rst = 1'b1;
      run_second(10, 10, "after_reset");
      n_cmp++;
      assert ({active_dir, green, remaining} === {2'd0, 4'b0001, 6'd3}) else begin
         n_bad++;
         $error("FAIL n_first dir/green/rem got %0d/%h/%0d want 0/1/3", active_dir, green,
                remaining);
      end

      // Long high level must produce exactly one tick.
      repeat (4) run_second(100, 20, "long_high");

      // Random requests and duty cycles.
      for (int s = 0; s < 40; s++) begin
         veh_req = 4'($urandom_range(0, 15));
         run_second($urandom_range(4, 15), $urandom_range(4, 15), "random");
      end

`ifdef PREEMPT_EN
      veh_req = 4'hF;
      do_reset("pre_reset");
      run_second(10, 10, "pre_n_green");
      preempt_valid = 1'b1;
      preempt_dir = 2'd2;
      clk_step("pre_force");
      n_cmp++;
      assert ({yellow, remaining} === {4'b0001, 6'd2}) else begin
         n_bad++;
         $error("FAIL pre_force yellow/rem got %h/%0d want 1/2", yellow, remaining);
      end
      repeat (8) run_second(10, 10, "pre_hold");
      n_cmp++;
      assert ({green, remaining} === {4'b0100, 6'd3}) else begin
         n_bad++;
         $error("FAIL pre_hold green/rem got %h/%0d want 4/3", green, remaining);
      end
      preempt_valid = 1'b0;
      repeat (6) run_second(10, 10, "pre_release");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
